accu_group: RTL

- Parametrised group accumulator with ready/valid handshakes on both input and output.
- Sums GROUP_N accepted input samples, or fewer when a group is closed early by last_in.
- Presents each group sum once in a held output register, together with the number of samples it contains.
- Sits between a sample stream and a downstream consumer that may apply backpressure.

---
 rtl/accu_group.sv | 68 ++++++
 1 files changed

// File: rtl/accu_group.sv
// Group accumulator: sums up to GROUP_N samples per group, early close on last_in.
// Ready/valid on both sides; the result sits in a held output register.
module accu_group #(
  parameter int DATA_W  = 8,
  parameter int GROUP_N = 4,
  parameter bit SIGNED  = 1'b0,
  localparam int OUT_W  = DATA_W + $clog2(GROUP_N),
  localparam int CNT_W  = $clog2(GROUP_N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [OUT_W-1:0]  data_out,
  output logic [CNT_W-1:0]  count_out
);

  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] sum;
  logic             sign_bit;
  logic             closing;
  logic             accept;
  logic             close;

  assign sign_bit = SIGNED ? data_in[DATA_W-1] : 1'b0;
  assign ext      = {{(OUT_W-DATA_W){sign_bit}}, data_in};
  assign sum      = acc + ext;

  // A closing beat needs the output register; other beats never do.
  assign closing  = (cnt == CNT_W'(GROUP_N - 1)) || last_in;
  assign ready_in = !(valid_out && !ready_out && closing);
  assign accept   = valid_in && ready_in;
  assign close    = accept && closing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (close) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      count_out <= '0;
    end else if (close) begin
      valid_out <= 1'b1;
      data_out  <= sum;
      count_out <= cnt + CNT_W'(1);
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule
